// File: rtl/up_info_line_ctrl_pkg.sv
// up_info_line_ctrl_pkg: shared widths, fetch length limit and FSM states for the upper info line controller
package up_info_line_ctrl_pkg;
  localparam int LINE_ADDR_BITS = 8;
  localparam int LINE_DATA_BITS = 16;
  localparam int MAX_FETCH_LEN = 16;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/up_info_line_ctrl_if.sv
// up_info_line_ctrl_if: fetch/neighbour/update handshakes and ram_d port of the upper info line controller
interface up_info_line_ctrl_if #(
  parameter int addr_bits = 8,
  parameter int data_bits = 16
);
  logic [addr_bits:0] pic_width_min;
  logic fetch_start;
  logic [addr_bits-1:0] fetch_x;
  logic [4:0] fetch_len;
  logic fetch_busy;
  logic nb_valid;
  logic [4:0] nb_idx;
  logic nb_avail;
  logic [data_bits-1:0] nb_data;
  logic upd_valid;
  logic [addr_bits-1:0] upd_x;
  logic [data_bits-1:0] upd_data;
  logic upd_ready;
  logic ram_en;
  logic ram_we;
  logic [addr_bits-1:0] ram_addra;
  logic [addr_bits-1:0] ram_addrb;
  logic [data_bits-1:0] ram_dia;
  logic [data_bits-1:0] ram_dob;
  modport slave (
    input pic_width_min, fetch_start, fetch_x, fetch_len, upd_valid, upd_x, upd_data, ram_dob,
    output fetch_busy, nb_valid, nb_idx, nb_avail, nb_data, upd_ready,
    output ram_en, ram_we, ram_addra, ram_addrb, ram_dia
  );
  modport master (
    output pic_width_min, fetch_start, fetch_x, fetch_len, upd_valid, upd_x, upd_data, ram_dob,
    input fetch_busy, nb_valid, nb_idx, nb_avail, nb_data, upd_ready,
    input ram_en, ram_we, ram_addra, ram_addrb, ram_dia
  );
endinterface

// File: rtl/up_info_line_ctrl.sv
// up_info_line_ctrl: sole ram_d master streaming up-left/up/up-right neighbour info and writing PU info back
module up_info_line_ctrl
  import up_info_line_ctrl_pkg::*;
#(
  parameter int addr_bits = LINE_ADDR_BITS,
  parameter int data_bits = LINE_DATA_BITS
) (
  input logic clk,
  input logic rst,
  up_info_line_ctrl_if.slave bus
);
  localparam int PW = addr_bits + 2;
  state_t r_state;
  logic [PW-1:0] r_pos;
  logic [PW-1:0] r_last;
  logic [4:0] r_idx;
  logic r_en;
  logic r_we;
  logic [addr_bits-1:0] r_addra;
  logic [addr_bits-1:0] r_addrb;
  logic [data_bits-1:0] r_dia;
  logic r_nb_valid;
  logic [4:0] r_nb_idx;
  logic r_nb_avail;
  logic [PW-1:0] w_next;
  logic w_avail;
  logic w_start;
  logic w_upd;
  logic w_done;
  assign w_start = (r_state == IDLE) && bus.fetch_start;
  assign w_upd = bus.upd_valid && bus.upd_ready;
  assign w_done = r_pos == r_last;
  assign w_next = (r_state == IDLE) ? {2'b00, bus.fetch_x} - PW'(1) : r_pos + PW'(1);
  assign w_avail = !w_next[PW-1] && (w_next < {1'b0, bus.pic_width_min});
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pos <= '0;
      r_last <= '0;
      r_idx <= '0;
      r_en <= 1'b0;
      r_we <= 1'b0;
      r_addra <= '0;
      r_addrb <= '0;
      r_dia <= '0;
      r_nb_valid <= 1'b0;
      r_nb_idx <= '0;
      r_nb_avail <= 1'b0;
    end else begin
      r_nb_valid <= r_state == FETCH;
      r_nb_avail <= (r_state == FETCH) && r_en;
      if (r_state == FETCH) r_nb_idx <= r_idx;
      case (r_state)
        IDLE: begin
          r_en <= w_start ? w_avail : w_upd;
          r_we <= w_upd;
          if (w_start) begin
            r_state <= FETCH;
            r_pos <= w_next;
            r_addrb <= w_next[addr_bits-1:0];
            r_last <= {2'b00, bus.fetch_x} + PW'(bus.fetch_len);
            r_idx <= '0;
          end
          if (w_upd) begin
            r_addra <= bus.upd_x;
            r_dia <= bus.upd_data;
          end
        end
        FETCH: begin
          r_we <= 1'b0;
          r_en <= !w_done && w_avail;
          if (w_done) r_state <= DRAIN;
          else begin
            r_pos <= w_next;
            r_addrb <= w_next[addr_bits-1:0];
            r_idx <= r_idx + 5'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_en <= 1'b0;
          r_we <= 1'b0;
        end
      endcase
    end
  end
  assign bus.fetch_busy = r_state != IDLE;
  assign bus.upd_ready = (r_state == IDLE) && !bus.fetch_start;
  assign bus.nb_valid = r_nb_valid;
  assign bus.nb_idx = r_nb_idx;
  assign bus.nb_avail = r_nb_avail;
  assign bus.nb_data = r_nb_avail ? bus.ram_dob : '0;
  assign bus.ram_en = r_en;
  assign bus.ram_we = r_we;
  assign bus.ram_addra = r_addra;
  assign bus.ram_addrb = r_addrb;
  assign bus.ram_dia = r_dia;
endmodule

// File: tb/tb_up_info_line_ctrl.sv
// tb_up_info_line_ctrl: random and directed fetch/update traffic checked against a column-array model
module tb_up_info_line_ctrl;
  import up_info_line_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  int width = 40;
  logic [15:0] ram [256];
  logic [15:0] ref_mem [256];
  up_info_line_ctrl_if #(.addr_bits(8), .data_bits(16)) bus ();
  up_info_line_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addra] <= bus.ram_dia;
      else bus.ram_dob <= ram[bus.ram_addrb];
    end
  always @(posedge clk)
    if (!rst && bus.fetch_start && !bus.fetch_busy)
      assert (bus.fetch_len >= 1 && bus.fetch_len <= MAX_FETCH_LEN)
      else $error("illegal fetch_len %0d", bus.fetch_len);
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit col_in(input int pos);
    return pos >= 0 && pos < width;
  endfunction
  task automatic upd(input int ux, input logic [15:0] ud);
    @(negedge clk);
    chk("upd_ready_idle", 32'(bus.upd_ready), 1);
    bus.upd_valid = 1'b1;
    bus.upd_x = 8'(ux);
    bus.upd_data = ud;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    chk("upd_en", 32'(bus.ram_en), 1);
    chk("upd_we", 32'(bus.ram_we), 1);
    chk("upd_addra", 32'(bus.ram_addra), 32'(ux));
    chk("upd_dia", 32'(bus.ram_dia), 32'(ud));
    ref_mem[ux] = ud;
  endtask
  task automatic fetch(input int x, input int len, input bit hold, input int ux, input logic [15:0] ud,
                       input bit poke);
    int pos;
    @(negedge clk);
    bus.fetch_start = 1'b1;
    bus.fetch_x = 8'(x);
    bus.fetch_len = 5'(len);
    if (hold) begin
      bus.upd_valid = 1'b1;
      bus.upd_x = 8'(ux);
      bus.upd_data = ud;
    end
    #1 chk("upd_ready_at_start", 32'(bus.upd_ready), 0);
    for (int c = 1; c <= len + 4; c++) begin
      @(negedge clk);
      chk("busy", 32'(bus.fetch_busy), 32'(c <= len + 3));
      pos = x + c - 2;
      chk("ram_en", 32'(bus.ram_en), 32'(c <= len + 2 && col_in(pos)));
      chk("ram_we", 32'(bus.ram_we), 0);
      if (c <= len + 2) chk("ram_addrb", 32'(bus.ram_addrb), 32'(pos & 255));
      chk("nb_valid", 32'(bus.nb_valid), 32'(c >= 2 && c <= len + 3));
      if (c >= 2 && c <= len + 3) begin
        pos = x + c - 3;
        chk("nb_idx", 32'(bus.nb_idx), 32'(c - 2));
        chk("nb_avail", 32'(bus.nb_avail), 32'(col_in(pos)));
        chk("nb_data", 32'(bus.nb_data), col_in(pos) ? 32'(ref_mem[pos]) : 0);
      end
      if (hold && c == len + 4) chk("upd_ready_after", 32'(bus.upd_ready), 1);
      bus.fetch_start = poke && c == 2;
      if (poke && c == 2) begin
        bus.fetch_x = 8'($urandom);
        bus.fetch_len = 5'($urandom_range(1, 16));
      end
    end
    if (hold) begin
      @(negedge clk);
      bus.upd_valid = 1'b0;
      chk("held_we", 32'(bus.ram_we), 1);
      chk("held_addra", 32'(bus.ram_addra), 32'(ux));
      chk("held_dia", 32'(bus.ram_dia), 32'(ud));
      ref_mem[ux] = ud;
    end
  endtask
  initial begin
    logic [15:0] v;
    int op;
    rst = 1'b1;
    bus.pic_width_min = 9'd40;
    bus.fetch_start = 1'b0;
    bus.fetch_x = '0;
    bus.fetch_len = 5'd1;
    bus.upd_valid = 1'b0;
    bus.upd_x = '0;
    bus.upd_data = '0;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.fetch_busy), 0);
    chk("rst_nb_valid", 32'(bus.nb_valid), 0);
    chk("rst_nb_avail", 32'(bus.nb_avail), 0);
    chk("rst_nb_idx", 32'(bus.nb_idx), 0);
    chk("rst_nb_data", 32'(bus.nb_data), 0);
    chk("rst_ram_en", 32'(bus.ram_en), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_addra", 32'(bus.ram_addra), 0);
    chk("rst_addrb", 32'(bus.ram_addrb), 0);
    chk("rst_dia", 32'(bus.ram_dia), 0);
    chk("rst_upd_ready", 32'(bus.upd_ready), 1);
    rst = 1'b0;
    fetch(4, 4, 0, 0, 0, 0);
    fetch(0, 2, 0, 0, 0, 0);
    fetch(36, 4, 0, 0, 0, 0);
    upd(5, 16'hABCD);
    fetch(5, 1, 0, 0, 0, 0);
    fetch(10, 3, 1, 7, 16'h1234, 0);
    fetch(6, 2, 0, 0, 0, 1);
    @(negedge clk);
    bus.fetch_start = 1'b1;
    bus.fetch_x = 8'd10;
    bus.fetch_len = 5'd8;
    @(negedge clk);
    bus.fetch_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_nb_valid", 32'(bus.nb_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_nb_valid", 32'(bus.nb_valid), 0);
    chk("mrst_busy", 32'(bus.fetch_busy), 0);
    chk("mrst_upd_ready", 32'(bus.upd_ready), 1);
    chk("mrst_ram_en", 32'(bus.ram_en), 0);
    chk("mrst_nb_idx", 32'(bus.nb_idx), 0);
    repeat (12) begin
      @(negedge clk);
      chk("mrst_no_beat", 32'(bus.nb_valid), 0);
    end
    for (int i = 0; i < 40; i++) begin
      width = $urandom_range(1, 256);
      bus.pic_width_min = 9'(width);
      op = $urandom_range(0, 3);
      if (op == 0) upd($urandom_range(0, 255), 16'($urandom));
      else fetch($urandom_range(0, (width + 1 > 255) ? 255 : width + 1), $urandom_range(1, 16), op == 3,
                 $urandom_range(0, 255), 16'($urandom), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
